// File: rtl/stopwatch_lap_core.sv
// Stopwatch core: run/stop/lap/clear FSM with an N-digit BCD counter that
// counts up (wrapping) or down from a preset (expiring), paced by a prescaler.
module stopwatch_lap_core #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 1000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_run_btn,
  input  logic                    i_clr_btn,
  input  logic                    i_lap_btn,
  input  logic                    i_mode,
  input  logic [4*NUM_DIGITS-1:0] i_preset,
  output logic [4*NUM_DIGITS-1:0] o_bcd,
  output logic                    o_run_on,
  output logic                    o_clr_on,
  output logic                    o_lap_on,
  output logic                    o_expired,
  output logic                    o_wrap
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_LAP, ST_CLEAR} state_t;

  // BCD increment with ripple carry; MSB of the result is the carry out of the top digit.
  function automatic logic [W:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic [3:0]   d;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = v[4*i +: 4];
      if (carry) begin
        if (d == 4'd9) begin
          d = 4'd0;
        end else begin
          d     = d + 4'd1;
          carry = 1'b0;
        end
      end
      r[4*i +: 4] = d;
    end
    return {carry, r};
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic [3:0]   d;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = v[4*i +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          d = 4'd9;
        end else begin
          d      = d - 4'd1;
          borrow = 1'b0;
        end
      end
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  state_t         state;
  logic [W-1:0]   count;
  logic [W-1:0]   lap_q;
  logic           mode_down;
  logic [PW-1:0]  presc;
  logic           run_q, clr_q, lap_btn_q;

  logic           run_edge, clr_edge, lap_edge;
  logic           counting, tick, expire;
  logic [W:0]     inc_res;
  logic [W-1:0]   dec_res;

  assign run_edge = i_run_btn & ~run_q;
  assign clr_edge = i_clr_btn & ~clr_q;
  assign lap_edge = i_lap_btn & ~lap_btn_q;

  assign counting = (state == ST_RUN) || (state == ST_LAP);
  assign tick     = counting && (presc == PW'(TICK_DIV - 1));
  assign inc_res  = bcd_inc(count);
  assign dec_res  = bcd_dec(count);
  assign expire   = tick && mode_down && (dec_res == '0);

  assign o_run_on = counting;
  assign o_clr_on = (state == ST_CLEAR);
  assign o_lap_on = (state == ST_LAP);

  // NOTE: every register here uses non-blocking assignment so all of them see
  // the pre-edge values of each other, matching the flop-to-flop behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_STOP;
      count     <= '0;
      lap_q     <= '0;
      mode_down <= 1'b0;
      presc     <= '0;
      // History tracks the live level while in reset, so a button held through
      // reset does not look like a fresh press once reset drops.
      run_q     <= i_run_btn;
      clr_q     <= i_clr_btn;
      lap_btn_q <= i_lap_btn;
      o_bcd     <= '0;
      o_expired <= 1'b0;
      o_wrap    <= 1'b0;
    end else begin
      run_q     <= i_run_btn;
      clr_q     <= i_clr_btn;
      lap_btn_q <= i_lap_btn;
      o_wrap    <= 1'b0;
      o_bcd     <= (state == ST_LAP) ? lap_q : count;

      if (counting) begin
        presc <= tick ? '0 : presc + PW'(1);
      end

      if (tick) begin
        if (!mode_down) begin
          {o_wrap, count} <= inc_res;
        end else begin
          count <= dec_res;
          if (expire) begin
            o_expired <= 1'b1;
          end
        end
      end

      unique case (state)
        ST_STOP: begin
          if (clr_edge) begin
            state <= ST_CLEAR;
          end else if (run_edge && !(mode_down && count == '0)) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (expire || run_edge) begin
            state <= ST_STOP;
          end else if (lap_edge) begin
            state <= ST_LAP;
            lap_q <= count;
          end
        end
        ST_LAP: begin
          if (expire || run_edge) begin
            state <= ST_STOP;
          end else if (lap_edge) begin
            state <= ST_RUN;
          end
        end
        ST_CLEAR: begin
          state     <= ST_STOP;
          mode_down <= i_mode;
          count     <= i_mode ? i_preset : '0;
          presc     <= '0;
          o_expired <= 1'b0;
        end
        default: state <= ST_STOP;
      endcase
    end
  end

endmodule
